// File: rtl/fact_ctrl.sv
// fact_ctrl: request/response sequencer for the factorial datapath.
// It accepts an operand on req_*, runs the datapath through
// LOAD/SETTLE/RUN/CAPT, and returns n! mod 2^SIZE on rsp_*.
// Operands 0 and 1 are answered locally, without starting the datapath.
// Optional build macro: FACT_CTRL_TIMEOUT_EN. When defined, RUN is aborted
// after TIMEOUT cycles and the response carries rsp_err=1 and rsp_result=0.
module fact_ctrl #(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 300
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SIZE-1:0] req_n,
  output logic [SIZE-1:0] dp_n,
  output logic            dp_init,
  output logic            dp_done,
  input  logic            dp_proceed,
  input  logic [SIZE-1:0] dp_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SIZE-1:0] rsp_result,
  output logic [SIZE-1:0] rsp_n,
  output logic            rsp_err,
  output logic            busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_CAPT   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]      state_r;
  logic [2:0]      next_state_s;
  logic            accept_s;
  logic            short_s;
  logic            timeout_s;
  logic [SIZE-1:0] dp_n_r;
  logic [SIZE-1:0] rsp_n_r;
  logic [SIZE-1:0] rsp_result_r;

  assign accept_s = (state_r == S_IDLE) && req_valid;
  assign short_s  = (req_n <= SIZE'(1));

`ifdef FACT_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] run_cnt_r;
  logic          rsp_err_r;

  // Abort when this RUN cycle is the TIMEOUT-th and the datapath still runs.
  assign timeout_s = (state_r == S_RUN) && dp_proceed &&
                     ((run_cnt_r + CW'(1)) == CW'(TIMEOUT));

  // RUN-cycle counter: cleared in SETTLE (just before RUN), counts in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_r <= '0;
    end else if (state_r == S_SETTLE) begin
      run_cnt_r <= '0;
    end else if (state_r == S_RUN) begin
      run_cnt_r <= run_cnt_r + CW'(1);
    end else begin
      run_cnt_r <= run_cnt_r;
    end
  end

  // Error flag: set by an abort, cleared by the next accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_r <= 1'b0;
    end else if (accept_s) begin
      rsp_err_r <= 1'b0;
    end else if (timeout_s) begin
      rsp_err_r <= 1'b1;
    end else begin
      rsp_err_r <= rsp_err_r;
    end
  end

  assign rsp_err = rsp_err_r;
`else
  logic [31:0] unused_timeout_s;

  assign unused_timeout_s = TIMEOUT;
  assign timeout_s        = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  // Next-state logic for the sequencing FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          if (short_s) begin
            next_state_s = S_RESP;
          end else begin
            next_state_s = S_LOAD;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_LOAD:   next_state_s = S_SETTLE;
      S_SETTLE: next_state_s = S_RUN;
      S_RUN: begin
        if (!dp_proceed) begin
          next_state_s = S_CAPT;
        end else if (timeout_s) begin
          next_state_s = S_RESP;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_CAPT: next_state_s = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_RESP;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand and result registers; they hold through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_n_r       <= '0;
      rsp_n_r      <= '0;
      rsp_result_r <= '0;
    end else begin
      if (accept_s) begin
        dp_n_r  <= req_n;
        rsp_n_r <= req_n;
      end else begin
        dp_n_r  <= dp_n_r;
        rsp_n_r <= rsp_n_r;
      end
      if (accept_s && short_s) begin
        rsp_result_r <= SIZE'(1);
      end else if (state_r == S_CAPT) begin
        rsp_result_r <= dp_result;
      end else if (timeout_s) begin
        rsp_result_r <= '0;
      end else begin
        rsp_result_r <= rsp_result_r;
      end
    end
  end

  // Handshake and datapath control decoded from the state register.
  // dp_done in RESP follows rsp_ready, so it pulses only on the handshake cycle.
  always_comb begin
    req_ready = 1'b0;
    dp_init   = 1'b0;
    dp_done   = 1'b1;
    rsp_valid = 1'b0;
    case (state_r)
      S_IDLE:   req_ready = 1'b1;
      S_LOAD:   dp_init   = 1'b1;
      S_SETTLE: dp_done   = 1'b1;
      S_RUN:    dp_done   = 1'b0;
      S_CAPT:   dp_done   = 1'b0;
      S_RESP: begin
        rsp_valid = 1'b1;
        dp_done   = rsp_ready;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign busy       = (state_r != S_IDLE);
  assign dp_n       = dp_n_r;
  assign rsp_n      = rsp_n_r;
  assign rsp_result = rsp_result_r;

endmodule

// File: tb/tb_fact_ctrl.sv
// tb_fact_ctrl: directed bench for fact_ctrl with a behavioural factorial
// datapath (load on init, multiply down while done=0, proceed=cnt>1).
module tb_fact_ctrl;

`ifdef FACT_CTRL_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 300;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_n = 8'd0;
  logic [7:0] dp_n;
  logic       dp_init;
  logic       dp_done;
  logic       dp_proceed;
  logic [7:0] dp_result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic [7:0] rsp_n;
  logic       rsp_err;
  logic       busy;

  int total = 0;
  int bad = 0;

  // datapath model state
  logic [7:0] m_cnt = 8'd0;
  logic [7:0] m_acc = 8'd0;
  logic       force_proceed = 1'b0;
  int         init_cnt = 0;

  fact_ctrl #(.SIZE(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .dp_n(dp_n), .dp_init(dp_init), .dp_done(dp_done),
    .dp_proceed(dp_proceed), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_n(rsp_n), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign dp_proceed = force_proceed | (m_cnt > 8'd1);
  assign dp_result  = m_acc;

  // Behavioural datapath: load on init, multiply-and-decrement while done=0.
  always_ff @(posedge clk) begin
    if (dp_init) begin
      m_cnt    <= dp_n;
      m_acc    <= 8'd1;
      init_cnt <= init_cnt + 1;
    end else if (!dp_done && m_cnt > 8'd1) begin
      m_cnt <= m_cnt - 8'd1;
      m_acc <= m_acc * m_cnt;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total = total + 1;
    if (obs !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  // One transaction: lat = negedges after the handshake until rsp_valid,
  // hold = cycles of back-pressure before accepting the response.
  task automatic do_req(input logic [7:0] n, input int lat, input logic [7:0] res,
                        input logic err, input int hold);
    int seen;
    int init0;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);
    init0     = init_cnt;
    req_valid = 1'b1;
    req_n     = n;
    @(negedge clk);
    req_valid = 1'b0;
    req_n     = 8'hAA;
    check_eq("req_ready_busy", req_ready, 0);
    check_eq("busy", busy, 1);
    seen = 0;
    while (!rsp_valid && seen < 400) begin
      @(negedge clk);
      seen = seen + 1;
    end
    check_eq("latency", seen, lat);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_result", rsp_result, res);
      check_eq("hold_done", dp_done, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_result", rsp_result, res);
    check_eq("rsp_n", rsp_n, n);
    check_eq("rsp_err", rsp_err, err);
    check_eq("done_pulse", dp_done, 1);
    check_eq("init_pulses", init_cnt - init0, (n <= 8'd1) ? 0 : 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", rsp_valid, 0);
    check_eq("back_idle", req_ready, 1);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_dp_init", dp_init, 0);
    check_eq("rst_dp_done", dp_done, 1);
    check_eq("rst_dp_n", dp_n, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_result", rsp_result, 0);
    check_eq("rst_rsp_n", rsp_n, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_busy", busy, 0);
  endtask

  initial begin
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Short path: answered locally, no init pulse, valid 1 cycle later.
    do_req(8'd0, 0, 8'd1, 1'b0, 0);
    do_req(8'd1, 0, 8'd1, 1'b0, 0);

`ifndef FACT_CTRL_TIMEOUT_EN
    // Normal run: latency = n + 3 negedges after handshake.
    do_req(8'd5, 8, 8'd120, 1'b0, 0);
    // Back-pressure: 720 mod 256 = 208 held for 10 cycles.
    do_req(8'd6, 9, 8'd208, 1'b0, 10);
    // Back-to-back.
    do_req(8'd3, 6, 8'd6, 1'b0, 0);
    do_req(8'd4, 7, 8'd24, 1'b0, 0);
    do_req(8'd5, 8, 8'd120, 1'b0, 0);

    // Reset during RUN of n=7.
    @(negedge clk);
    req_valid = 1'b1;
    req_n     = 8'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_run_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    do_req(8'd4, 7, 8'd24, 1'b0, 0);
`else
    do_req(8'd3, 6, 8'd6, 1'b0, 0);
    do_req(8'd4, 7, 8'd24, 1'b0, 0);
    // Stuck datapath: abort after 4 RUN cycles (RESP at negedge 6).
    force_proceed = 1'b1;
    do_req(8'd5, 6, 8'd0, 1'b1, 0);
    force_proceed = 1'b0;
    do_req(8'd3, 6, 8'd6, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fact_ctrl.md
# fact_ctrl

Sequencing controller placed directly upstream of the factorial datapath (`dp`). It accepts an operand `n` on a valid/ready request port, drives the datapath's `n`/`init`/`done` inputs, detects completion from `proceed`, and captures `result`. It then presents `n!` (truncated to SIZE bits) on a valid/ready response port. Operands 0 and 1 are answered locally without starting the datapath.

## Interface
- SIZE, 8, operand/result width; must match the datapath's SIZE
- TIMEOUT, 300, maximum RUN cycles before abort (used only with FACT_CTRL_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request operand valid
- req_ready  out  1  controller idle, can accept
- req_n  in  SIZE  operand
- dp_n  out  SIZE  registered operand to datapath `n`
- dp_init  out  1  datapath `init`
- dp_done  out  1  datapath `done`
- dp_proceed  in  1  datapath `proceed`
- dp_result  in  SIZE  datapath `result`
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  SIZE  n! mod 2^SIZE
- rsp_n  out  SIZE  echo of accepted operand
- rsp_err  out  1  response aborted by timeout
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, SETTLE, RUN, CAPT, RESP.
- IDLE:
  - req_ready=1, dp_done=1.
  - On req_valid, register req_n into dp_n/rsp_n.
  - If req_n<=1, go to RESP with rsp_result=1 and no dp_init pulse; otherwise go to LOAD.
- LOAD (1 cycle): dp_init=1, dp_done=1.
- SETTLE (1 cycle):
  - dp_init=0, dp_done=1.
  - Its purpose is to clear the datapath's latch arm while `proceed` carries the freshly loaded comparison.
  - dp_proceed is ignored in LOAD and SETTLE.
- RUN: dp_done=0. Wait for dp_proceed==0, then go to CAPT.
- CAPT (1 cycle): dp_done=0. At the exit edge, register dp_result into rsp_result, then go to RESP.
- RESP:
  - rsp_valid=1.
  - On rsp_valid&&rsp_ready: pulse dp_done=1 for that cycle and go to IDLE.
- Outputs dp_n, rsp_result, rsp_n and rsp_err are registers and hold stable throughout RESP.
- No overflow detection; the result is the low SIZE bits.
- req_valid is ignored outside IDLE; no request queueing.

## Timing
- Reset values: state=IDLE, req_ready=1 on release, dp_init=0, dp_done=1 (IDLE decode), dp_n=0, rsp_valid=0, rsp_result=0, rsp_n=0, rsp_err=0, busy=0.
- Reset mid-operation: return to IDLE immediately. The next request always passes through LOAD/SETTLE, so no stale datapath result is returned.
- Request accept: handshake edge → LOAD in next cycle → SETTLE → RUN.
- Completion: rsp_valid asserts exactly 2 cycles after the first RUN cycle sampling dp_proceed==0.
- Short path (n<=1): rsp_valid asserts 1 cycle after the handshake.
- Back-pressure: RESP holds indefinitely while rsp_ready=0; dp_done stays 0 until acceptance.
- Back-to-back: after a response handshake, IDLE is reached the next cycle, so there is 1 idle cycle minimum between transactions.
- req_valid in the same cycle as a reset release is ignored.

## Configuration
- FACT_CTRL_TIMEOUT_EN defined:
  - A RUN-cycle counter (clog2(TIMEOUT+1) bits) clears on entering RUN.
  - If it reaches TIMEOUT with dp_proceed still 1, go to RESP with rsp_err=1 and rsp_result=0.
  - rsp_err clears on the next request acceptance.
- FACT_CTRL_TIMEOUT_EN undefined: no counter is built, rsp_err is tied to 0, and RUN waits indefinitely.

## Test plan
- Reset then req_n=5 with rsp_ready=1 → one dp_init pulse, then rsp_result=120, rsp_n=5, rsp_err=0.
- req_n=0, then req_n=1 → rsp_result=1 each time, dp_init never asserted, rsp_valid 1 cycle after handshake.
- req_n=6 with rsp_ready=0 for 10 cycles → rsp_valid/rsp_result=208 (720 mod 256) held stable, dp_done=0 until the handshake cycle.
- Back-to-back requests 3, 4, 5 → 6, 24, 120 in order; req_ready low from acceptance until return to IDLE.
- Assert rst_n low during RUN of req_n=7, then request 4 → all outputs at reset values during reset, then rsp_result=24.
- With FACT_CTRL_TIMEOUT_EN, TIMEOUT=4, and dp_proceed forced 1 → rsp_err=1 and rsp_result=0 after 4 RUN cycles; a following normal req_n=3 gives rsp_err=0 and rsp_result=6.
